// File: rtl/ising_host_seq_if.sv
// Register bus between the host sequencer and an ising_axi instance.
// The host writes one word per cycle while wready is high and drives a read address.
interface ising_host_seq_if;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic [31:0] araddr;
  logic [31:0] rdata;

  modport master (output wready, wr_addr, wdata, araddr, input rdata);
  modport slave  (input wready, wr_addr, wdata, araddr, output rdata);
endinterface

// File: rtl/ising_host_seq.sv
// Host sequencer: buffers graph edges, programs an ising_axi instance, runs it for a
// fixed time and reads the phases back into a thresholded spin vector.
module ising_host_seq #(
  parameter int          N                = 8,
  parameter int          NUM_WEIGHTS      = 3,
  parameter int          EDGE_DEPTH       = 16,
  parameter int          CUTOFF           = 4,
  parameter int          CTR_MAX          = 8,
  parameter int          RUN_CYCLES       = 600,
  parameter int          READ_LAT         = 1,
  parameter logic [31:0] START_ADDR       = 32'h0000_0000,
  parameter logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004,
  parameter logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008,
  parameter logic [31:0] PHASE_ADDR_BASE  = 32'h0000_0100,
  parameter logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   edge_valid,
  output logic                   edge_ready,
  input  logic [$clog2(N)-1:0]   edge_i,
  input  logic [$clog2(N)-1:0]   edge_j,
  input  logic [NUM_WEIGHTS-1:0] edge_w,
  output logic                   busy,
  output logic                   done,
  output logic [N-1:0]           spins,
  ising_host_seq_if.master       bus
);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(EDGE_DEPTH);
  localparam int EW = 2 * IW + NUM_WEIGHTS;

  typedef enum logic [2:0] {IDLE, W_CUT, W_MAX, W_EDGE, RUN, STOP, READ, DONE} state_t;

  state_t        state_q;
  logic          busy_q, done_q, wready_q;
  logic [31:0]   wr_addr_q, wdata_q, araddr_q;
  logic [31:0]   cnt_q, lat_q;
  logic [IW-1:0] k_q;
  logic [N-1:0]  spins_q;

  logic [EW-1:0] fifo_mem [EDGE_DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          full, empty, push;
  logic [EW-1:0] head;
  logic [IW-1:0] head_i, head_j, lo, hi;
  logic [NUM_WEIGHTS-1:0] head_w;
  logic [31:0]   edge_addr;

  // Extra pointer bit distinguishes a full FIFO from an empty one.
  assign full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign edge_ready = !busy_q && !full;
  assign push       = edge_valid && edge_ready;

  assign head      = fifo_mem[rd_ptr_q[PW-1:0]];
  assign head_i    = head[EW-1 -: IW];
  assign head_j    = head[NUM_WEIGHTS +: IW];
  assign head_w    = head[NUM_WEIGHTS-1:0];
  assign lo        = (head_i < head_j) ? head_i : head_j;
  assign hi        = (head_i < head_j) ? head_j : head_i;
  assign edge_addr = WEIGHT_ADDR_BASE + (32'(lo) << 2) + (32'(hi) << 13);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= {edge_i, edge_j, edge_w};
  end

  // Outputs for a state are loaded on the edge that enters it, so the bus is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wready_q  <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      k_q       <= '0;
      spins_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= W_CUT;
            busy_q    <= 1'b1;
            wready_q  <= 1'b1;
            wr_addr_q <= CTR_CUTOFF_ADDR;
            wdata_q   <= 32'(CUTOFF);
          end
        end
        W_CUT: begin
          state_q   <= W_MAX;
          wr_addr_q <= CTR_MAX_ADDR;
          wdata_q   <= 32'(CTR_MAX);
        end
        W_MAX, W_EDGE: begin
          if (!empty) begin
            state_q   <= W_EDGE;
            rd_ptr_q  <= rd_ptr_q + (PW+1)'(1);
            wready_q  <= (head_i != head_j);
            wr_addr_q <= edge_addr;
            wdata_q   <= 32'(head_w);
          end else begin
            state_q   <= RUN;
            wready_q  <= 1'b1;
            wr_addr_q <= START_ADDR;
            wdata_q   <= 32'd1;
            cnt_q     <= '0;
          end
        end
        RUN: begin
          // Cycle with cnt_q==0 is the START=1 write; RUN_CYCLES idle cycles follow.
          if (cnt_q == 32'(RUN_CYCLES)) begin
            state_q   <= STOP;
            wready_q  <= 1'b1;
            wr_addr_q <= START_ADDR;
            wdata_q   <= 32'd0;
          end else begin
            wready_q <= 1'b0;
            cnt_q    <= cnt_q + 32'd1;
          end
        end
        STOP: begin
          state_q  <= READ;
          wready_q <= 1'b0;
          araddr_q <= PHASE_ADDR_BASE;
          k_q      <= '0;
          lat_q    <= '0;
        end
        READ: begin
          if (lat_q == 32'(READ_LAT - 1)) begin
            spins_q[k_q] <= (bus.rdata >= 32'(CUTOFF));
            lat_q        <= '0;
            if (k_q == IW'(N - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              k_q      <= k_q + IW'(1);
              araddr_q <= PHASE_ADDR_BASE + ((32'(k_q) + 32'd1) << 2);
            end
          end else begin
            lat_q <= lat_q + 32'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign spins       = spins_q;
  assign bus.wready  = wready_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.araddr  = araddr_q;
endmodule

// File: tb/tb_ising_host_seq.sv
// Bench for ising_host_seq: register-model responder, expected-write scoreboard built from
// the pushed edge list, and directed scenarios with literal expectations.
module tb_ising_host_seq;
  localparam int N = 8, NW = 3, DEPTH = 16, CUTOFF = 4, CTR_MAX = 8, RUN_CYCLES = 600, READ_LAT = 1;
  localparam logic [31:0] START_A = 32'h0, CUT_A = 32'h4, MAX_A = 32'h8;
  localparam logic [31:0] PH_A = 32'h100, W_A = 32'h0001_0000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, edge_valid = 1'b0;
  logic edge_ready, busy, done;
  logic [2:0] edge_i = '0, edge_j = '0;
  logic [NW-1:0] edge_w = '0;
  logic [N-1:0] spins;

  ising_host_seq_if bus();

  ising_host_seq #(
    .N(N), .NUM_WEIGHTS(NW), .EDGE_DEPTH(DEPTH), .CUTOFF(CUTOFF), .CTR_MAX(CTR_MAX),
    .RUN_CYCLES(RUN_CYCLES), .READ_LAT(READ_LAT), .START_ADDR(START_A),
    .CTR_CUTOFF_ADDR(CUT_A), .CTR_MAX_ADDR(MAX_A), .PHASE_ADDR_BASE(PH_A),
    .WEIGHT_ADDR_BASE(W_A)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_i(edge_i), .edge_j(edge_j), .edge_w(edge_w), .busy(busy), .done(done),
    .spins(spins), .bus(bus)
  );

  always #5 clk = ~clk;

  // Responder: with READ_LAT=1 the phase for araddr must be present before the next edge.
  int phase [N] = '{6, 2, 5, 7, 1, 0, 0, 4};
  logic [2:0] ph_idx;
  logic       ph_hit;
  assign ph_idx = 3'((bus.araddr - PH_A) >> 2);
  assign ph_hit = (bus.araddr >= PH_A) && (bus.araddr < PH_A + 32'(4 * N));
  assign bus.rdata = ph_hit ? 32'(phase[ph_idx]) : 32'h0;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int i; int j; int w; } edge_t;

  wr_t   exp_q[$];
  wr_t   log_q[$];
  edge_t fifo_m[$];
  wr_t   got_w, exp_w;
  int    checks = 0, errors = 0;
  int    cyc = 0, start1_cyc = 0, start0_cyc = 0, done_cnt = 0;
  logic  job_active = 1'b0;
  logic [N-1:0] exp_spins = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wready) begin
        got_w = '{bus.wr_addr, bus.wdata};
        log_q.push_back(got_w);
        if (got_w.addr == START_A && got_w.data == 32'd1) start1_cyc = cyc;
        if (got_w.addr == START_A && got_w.data == 32'd0) start0_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=0x%08h/0x%08h expected=none", got_w.addr, got_w.data);
        end else begin
          exp_w = exp_q.pop_front();
          $display("write addr=0x%08h data=0x%08h", got_w.addr, got_w.data);
          chk("wr_addr", got_w.addr, exp_w.addr);
          chk("wr_data", got_w.data, exp_w.data);
        end
      end
      if (done) begin
        done_cnt++;
        chk("spins_at_done", 32'(spins), 32'(exp_spins));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input int j, input int w);
    logic exp_rdy;
    exp_rdy = !job_active && (fifo_m.size() < DEPTH);
    edge_valid = 1'b1;
    edge_i = 3'(i);
    edge_j = 3'(j);
    edge_w = NW'(w);
    chk("edge_ready", 32'(edge_ready), 32'(exp_rdy));
    if (exp_rdy) fifo_m.push_back(edge_t'{i, j, w});
    tick();
    edge_valid = 1'b0;
  endtask

  task automatic launch_job();
    int lo, hi;
    exp_q.delete();
    log_q.delete();
    done_cnt = 0;
    exp_q.push_back('{CUT_A, 32'(CUTOFF)});
    exp_q.push_back('{MAX_A, 32'(CTR_MAX)});
    foreach (fifo_m[n]) begin
      if (fifo_m[n].i != fifo_m[n].j) begin
        lo = (fifo_m[n].i < fifo_m[n].j) ? fifo_m[n].i : fifo_m[n].j;
        hi = (fifo_m[n].i < fifo_m[n].j) ? fifo_m[n].j : fifo_m[n].i;
        exp_q.push_back('{W_A + 32'(lo * 4) + 32'(hi * 8192), 32'(fifo_m[n].w)});
      end
    end
    exp_q.push_back('{START_A, 32'd1});
    exp_q.push_back('{START_A, 32'd0});
    fifo_m.delete();
    for (int k = 0; k < N; k++) exp_spins[k] = (phase[k] >= CUTOFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    job_active = 1'b1;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int exp_writes);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
    job_active = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("write_count", 32'(log_q.size()), 32'(exp_writes));
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("job done spins=0x%02h writes=%0d", spins, log_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_spins", 32'(spins), 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_wr_addr", bus.wr_addr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    log_q.delete();
    fifo_m.delete();
    job_active = 1'b0;
    chk("rst_edge_ready", 32'(edge_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    do_reset();

    // Graph A..H: five-node ring-ish core with every node tied to H.
    push(0, 1, 1); push(0, 4, 1); push(1, 2, 1); push(1, 3, 1); push(2, 3, 1); push(3, 4, 1);
    push(0, 7, 4); push(1, 7, 4); push(2, 7, 4); push(3, 7, 4); push(4, 7, 4);
    launch_job();
    wait_done(15);
    chk("lit_spins", 32'(spins), 32'h8D);
    chk("lit_cut", log_q[0].data, 32'd4);
    chk("lit_max", log_q[1].data, 32'd8);
    chk("lit_ab_addr", log_q[2].addr, 32'h0001_2000);
    chk("lit_ab_data", log_q[2].data, 32'd1);
    chk("lit_start1", log_q[13].data, 32'd1);
    chk("lit_start0", log_q[14].data, 32'd0);
    chk("lit_run_gap", 32'(start0_cyc - start1_cyc), 32'd601);

    // Reversed indices and a self edge.
    push(3, 1, 2); push(2, 2, 5);
    launch_job();
    chk("spins_held", 32'(spins), 32'h8D);
    wait_done(5);
    chk("lit_31_addr", log_q[2].addr, 32'h0001_6004);
    chk("lit_31_data", log_q[2].data, 32'd2);
    chk("lit_after_self", log_q[3].data, 32'd1);

    // FIFO overflow, then pokes while busy.
    for (int k = 0; k < 17; k++) begin
      push(k % 8, (k + 1) % 8, k % 8);
      if (k == 15) chk("lit_full_ready", 32'(edge_ready), 32'd0);
    end
    launch_job();
    push(0, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20);
    tick(); tick();
    chk("start_busy_ignored", 32'(busy), 32'd0);

    // Reset in the middle of the weight phase.
    push(0, 1, 1); push(0, 4, 1); push(1, 2, 1); push(1, 3, 1); push(2, 3, 1); push(3, 4, 1);
    launch_job();
    tick(); tick(); tick(); tick();
    do_reset();

    // Reset in the middle of the read-back.
    push(0, 1, 3); push(2, 5, 7);
    launch_job();
    n = 0;
    while (log_q.size() < 6 && n < 3000) begin
      tick();
      n++;
    end
    chk("reached_read", 32'(log_q.size()), 32'd6);
    tick(); tick(); tick();
    chk("lit_partial_spins", 32'(spins), 32'h05);
    do_reset();

    // Fresh job must see an empty FIFO from the aborted ones.
    push(6, 1, 2); push(4, 4, 3); push(5, 0, 6);
    launch_job();
    wait_done(6);
    chk("lit_final_spins", 32'(spins), 32'h8D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ising_host_seq.md
ISING_HOST_SEQ -- requirements
Module: ising_host_seq

Interface
REQ-001 Parameter N, default 8, number of spins; must match the attached ising_axi instance.
REQ-002 Parameter NUM_WEIGHTS, default 3, weight code width in bits.
REQ-003 Parameter EDGE_DEPTH, default 16, edge FIFO depth, power of two.
REQ-004 Parameter CUTOFF, default 4, value written to CTR_CUTOFF_ADDR and used as spin threshold.
REQ-005 Parameter CTR_MAX, default 8, value written to CTR_MAX_ADDR.
REQ-006 Parameter RUN_CYCLES, default 600, clock cycles START is held at 1.
REQ-007 Parameter READ_LAT, default 1, clock edges from araddr update to valid rdata; minimum 1.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 start  in  1  one-cycle job launch request.
REQ-011 edge_valid  in  1  edge push request.
REQ-012 edge_ready  out  1  edge push accepted this cycle when high with edge_valid.
REQ-013 edge_i, edge_j  in  $clog2(N) each  spin indices of the edge.
REQ-014 edge_w  in  NUM_WEIGHTS  weight code.
REQ-015 busy  out  1  job in progress.
REQ-016 done  out  1  one-cycle pulse at job end.
REQ-017 spins  out  N  result; bit k = spin k.
REQ-018 wready  out  1  register write strobe to ising_axi.
REQ-019 wr_addr  out  32  write address.
REQ-020 wdata  out  32  write data.
REQ-021 araddr  out  32  read address (ising_axi araddr_q; arvalid tied high externally).
REQ-022 rdata  in  32  read data from ising_axi.

Function
REQ-023 FIFO push when edge_valid && edge_ready; edge_ready = !busy && !full; push while busy or full dropped, no FIFO change.
REQ-024 start accepted only when !busy; start while busy ignored; empty FIFO allowed (weight phase skipped).
REQ-025 FSM states IDLE, W_CUT, W_MAX, W_EDGE, RUN, STOP, READ, DONE; each write state issues exactly one single-cycle write (wready=1); wready=0 in all other cycles.
REQ-026 IDLE->W_CUT on accepted start; busy=1 from the next cycle until DONE exits.
REQ-027 W_CUT: wr_addr=CTR_CUTOFF_ADDR, wdata=CUTOFF; W_MAX: wr_addr=CTR_MAX_ADDR, wdata=CTR_MAX.
REQ-028 W_EDGE: one FIFO pop and one write per cycle until empty; lo=min(i,j), hi=max(i,j); wr_addr=WEIGHT_ADDR_BASE+(lo<<2)+(hi<<13); wdata=zero-extended edge_w.
REQ-029 Edge with i==j popped with no write (wready=0 that cycle).
REQ-030 RUN: first cycle writes START_ADDR with wdata=1; then idles RUN_CYCLES cycles via counter.
REQ-031 STOP: writes START_ADDR with wdata=0, then -> READ with k=0.
REQ-032 READ: araddr=PHASE_ADDR_BASE+(k<<2) registered; rdata captured exactly READ_LAT edges after araddr update; spins[k] = (rdata >= CUTOFF); k increments after capture; after k=N-1 -> DONE.
REQ-033 araddr holds last value outside READ; spins holds value from last completed job until overwritten bit-by-bit in READ.
REQ-034 DONE: done=1 for one cycle, -> IDLE; busy=0 in the cycle after DONE.
REQ-035 Total write count per job = 4 + number of edges with i!=j.

Reset
REQ-036 rst=1 at an edge: state IDLE, FIFO emptied, counters 0, wready=0, wr_addr=wdata=araddr=0, busy=0, done=0, spins=0; applies mid-job with no further writes.
REQ-037 Aborted mid-RUN job leaves START unwritten to 0; system-level requirement that ising_axi is reset alongside.

Verification
REQ-038 Bench pairs DUT with a register-model responder logging writes and returning programmed phases after READ_LAT.
REQ-039 Push AB,AE,BC,BD,CD,DE w=1 and AH,BH,CH,DH,EH w=4, start -> 15 writes in order: CUTOFF=4, MAX=8, 11 weights (AB addr=BASE+(0<<2)+(1<<13), data 1), START=1, START=0 after 600 idle cycles.
REQ-040 Model phases A=6,B=2,C=5,D=7,E=1,F=0,G=0,H=4 -> spins=8'h8D, done pulse exactly once, busy low next cycle.
REQ-041 Push (3,1,w=2) and (2,2,w=5) -> one weight write at BASE+(1<<2)+(3<<13) data 2; self-edge no write.
REQ-042 Push 17 edges with EDGE_DEPTH=16 -> edge_ready low after 16th, 17th dropped; start during busy ignored; push during busy refused.
REQ-043 rst asserted mid-W_EDGE and mid-READ -> next cycle wready=0, busy=0, spins=0; fresh job afterwards completes with correct 4+edge write count.
